// File: rtl/pair_shuffler.sv
// Card dealer: builds a deck of 2*PAIRS cards (each pair ID twice) and shuffles it
// in place with a Fisher-Yates pass indexed by a free-running Galois LFSR.
module pair_shuffler #(
    parameter int          PAIRS = 8,
    parameter int          ID_W  = 3,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      reseed,
    input  logic [15:0]               seed_in,
    output logic [2*PAIRS*ID_W-1:0]   deck,
    output logic                      busy,
    output logic                      done
);
    localparam int N      = 2 * PAIRS;
    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = 8 + IDX_W + 1;

    typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;
    logic [ID_W-1:0]  cards [N];

    function automatic logic [ID_W-1:0] canon(input int k);
        return ID_W'(k >> 1);
    endfunction

    // Scaling an 8-bit random value by (idx+1) and dropping 8 bits keeps j in 0..idx.
    assign j = IDX_W'((PROD_W'(lfsr[7:0]) * (PROD_W'(idx) + PROD_W'(1))) >> 8);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (reseed) begin
            lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                state_next = SHUFFLE;
            end
            SHUFFLE: begin
                busy = 1'b1;
                if (idx == IDX_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A swap with j == idx writes the same card back, so it needs no special case.
    always_ff @(posedge clk) begin
        if (reset || state == INIT) begin
            for (int k = 0; k < N; k++) begin
                cards[k] <= canon(k);
            end
            idx <= IDX_W'(N - 1);
        end else if (state == SHUFFLE) begin
            cards[idx] <= cards[j];
            cards[j]   <= cards[idx];
            idx        <= idx - IDX_W'(1);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_deck
        assign deck[k*ID_W +: ID_W] = cards[k];
    end
endmodule

// File: tb/tb_pair_shuffler.sv
// Directed bench for pair_shuffler: PAIRS=8 table vectors and corner sequences,
// plus a PAIRS=4 / PAIRS=32 sweep, all checked against a reference Fisher-Yates model.
module tb_pair_shuffler;
    typedef int deck_t [128];
    typedef struct {
        string       name;
        int          mode;      // 0: reseed before start, 1: reset+reseed before start
        logic [15:0] seed;
        int          gap;       // idle edges between reseed and start
        bit          extra;     // extra start pulses at E3 and E10
        int          exp_lat;
        int          exp_nd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start_sw, reseed;
    logic [15:0] seed_in;
    logic [47:0]  deck8;
    logic [15:0]  deck4;
    logic [319:0] deck32;
    logic busy8, done8, busy4, done4, busy32, done32;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[15];
    logic [47:0] saved[15];

    pair_shuffler #(.PAIRS(8), .ID_W(3), .SEED(16'hACE1)) dut8 (
        .clk(clk), .reset(reset), .start(start), .reseed(reseed), .seed_in(seed_in),
        .deck(deck8), .busy(busy8), .done(done8));
    pair_shuffler #(.PAIRS(4), .ID_W(2), .SEED(16'hACE1)) dut4 (
        .clk(clk), .reset(reset), .start(start_sw), .reseed(reseed), .seed_in(seed_in),
        .deck(deck4), .busy(busy4), .done(done4));
    pair_shuffler #(.PAIRS(32), .ID_W(5), .SEED(16'hACE1)) dut32 (
        .clk(clk), .reset(reset), .start(start_sw), .reseed(reseed), .seed_in(seed_in),
        .deck(deck32), .busy(busy32), .done(done32));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void canon_deck(input int n, output deck_t d);
        for (int k = 0; k < 128; k++) d[k] = (k < n) ? k / 2 : 0;
    endfunction

    // Reference deck: LFSR holds seed after the reseed edge and steps once per edge;
    // the first swap uses the value present after E1.
    function automatic void model(input int n, input logic [15:0] seed, input int gap,
                                  output deck_t d);
        logic [15:0] l;
        int j, t;
        canon_deck(n, d);
        l = seed;
        for (int g = 0; g < gap + 2; g++) l = lfsr_step(l);
        for (int i = n - 1; i >= 1; i--) begin
            j = (int'(l[7:0]) * (i + 1)) >> 8;
            t = d[i]; d[i] = d[j]; d[j] = t;
            l = lfsr_step(l);
        end
    endfunction

    function automatic logic [31:0] card(input logic [319:0] d, input int idw, input int k);
        logic [319:0] mask, x;
        mask = (320'd1 << idw) - 320'd1;
        x = (d >> (k * idw)) & mask;
        return x[31:0];
    endfunction

    task automatic compare_deck(input string name, input logic [319:0] d, input int n,
                                input int idw, input deck_t m);
        int bad, inv_bad, c;
        int cnt[64];
        logic [7:0] got, exp;
        bad = 0;
        inv_bad = 0;
        for (int k = 0; k < n; k++) exp_q.push_back(8'(m[k]));
        for (int k = 0; k < n; k++) begin
            got = 8'(card(d, idw, k));
            exp = exp_q.pop_front();
            if (got !== exp) bad++;
        end
        for (int p = 0; p < 64; p++) cnt[p] = 0;
        for (int k = 0; k < n; k++) begin
            c = int'(card(d, idw, k));
            if (c < n / 2) cnt[c]++;
            else inv_bad++;
        end
        for (int p = 0; p < n / 2; p++) if (cnt[p] != 2) inv_bad++;
        check({name, " wrong_cards"}, bad, 0);
        check({name, " pair_count_errors"}, inv_bad, 0);
    endtask

    // Called and returns on a falling edge.
    task automatic prep(input int mode, input logic [15:0] s, input int gap);
        seed_in = s;
        reseed = 1'b1;
        if (mode == 1) reset = 1'b1;
        @(negedge clk);
        reseed = 1'b0;
        reset = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run8(input vec_t v, output logic [47:0] result);
        deck_t m;
        int lat, nd;
        logic [15:0] eff;
        prep(v.mode, v.seed, v.gap);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        nd = 0;
        for (int k = 1; k <= v.exp_lat + 6; k++) begin
            start = v.extra && (k == 3 || k == 10);
            @(negedge clk);
            if (k == 1) check({v.name, " busy_after_e1"}, busy8, 1);
            if (done8) begin
                nd++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
        check({v.name, " done_latency"}, lat, v.exp_lat);
        check({v.name, " done_pulses"}, nd, v.exp_nd);
        check({v.name, " busy_idle"}, busy8, 0);
        eff = (v.mode == 1 || v.seed == 16'h0000) ? 16'hACE1 : v.seed;
        model(16, eff, v.gap, m);
        compare_deck(v.name, {272'b0, deck8}, 16, 3, m);
        result = deck8;
    endtask

    task automatic run_sweep(input int it);
        deck_t m;
        int lat4, lat32, n4, n32, gap;
        logic [15:0] s;
        s = 16'h0F00 ^ 16'(it * 1237 + 1);
        gap = it % 4;
        prep(0, s, gap);
        start_sw = 1'b1;
        @(negedge clk);
        start_sw = 1'b0;
        lat4 = -1; lat32 = -1; n4 = 0; n32 = 0;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (done4) begin n4++; if (lat4 < 0) lat4 = k; end
            if (done32) begin n32++; if (lat32 < 0) lat32 = k; end
        end
        check($sformatf("sweep%0d p4 latency", it), lat4, 8);
        check($sformatf("sweep%0d p4 pulses", it), n4, 1);
        check($sformatf("sweep%0d p32 latency", it), lat32, 64);
        check($sformatf("sweep%0d p32 pulses", it), n32, 1);
        model(8, s, gap, m);
        compare_deck($sformatf("sweep%0d p4", it), {304'b0, deck4}, 8, 2, m);
        model(64, s, gap, m);
        compare_deck($sformatf("sweep%0d p32", it), deck32, 64, 5, m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        deck_t c;
        int nd;
        int gaps[10] = '{0, 1, 2, 3, 5, 7, 4, 9, 6, 11};

        for (int i = 0; i < 10; i++)
            vecs[i] = '{$sformatf("basic%0d", i), 0, 16'h1234, gaps[i], 1'b0, 16, 1};
        vecs[10] = '{"repro_1234",  0, 16'h1234, 0, 1'b0, 16, 1};
        vecs[11] = '{"zero_seed",   0, 16'h0000, 0, 1'b0, 16, 1};
        vecs[12] = '{"seed_ace1",   0, 16'hACE1, 0, 1'b0, 16, 1};
        vecs[13] = '{"reset_prio",  1, 16'h1234, 0, 1'b0, 16, 1};
        vecs[14] = '{"busy_protect", 0, 16'h1234, 2, 1'b1, 16, 1};

        reset = 1'b1; start = 1'b0; start_sw = 1'b0; reseed = 1'b0; seed_in = 16'h0;
        repeat (2) @(negedge clk);
        canon_deck(16, c);
        compare_deck("reset p8", {272'b0, deck8}, 16, 3, c);
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        canon_deck(8, c);
        compare_deck("reset p4", {304'b0, deck4}, 8, 2, c);
        canon_deck(64, c);
        compare_deck("reset p32", deck32, 64, 5, c);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run8(vecs[i], saved[i]);
        check("repro same seed", saved[10] == saved[0], 1);
        check("repro zero seed", saved[11] == saved[12], 1);
        check("repro reset seed", saved[13] == saved[12], 1);
        check("repro busy protect", saved[14] == saved[2], 1);

        // Reset landing on E5 of a shuffle.
        prep(0, 16'h1234, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        canon_deck(16, c);
        compare_deck("mid_reset", {272'b0, deck8}, 16, 3, c);
        check("mid_reset busy", busy8, 0);
        check("mid_reset done", done8, 0);
        nd = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("mid_reset no_done", nd, 0);
        run8('{"post_reset", 0, 16'h5A5A, 1, 1'b0, 16, 1}, saved[0]);

        for (int it = 0; it < 20; it++) run_sweep(it);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
